// File: rtl/axi_hp_burst_reader_pkg.sv
// rtl/axi_hp_burst_reader_pkg.sv - shared constants, state encoding and burst sizing helper
package axi_hp_burst_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_SIZE_64    = 2'h3;
    localparam int         AXI_4KB_WORDS  = 512;   // 64-bit words per 4 KB page
    localparam int         MAX_BURST_BEATS = 16;
    localparam int         LEN_FIFO_DEPTH_LOG2 = 3; // 8 entries covers MAX_OUTSTANDING up to 8

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // Beats for the next burst: limited by the burst cap, the words still owed
    // and the distance to the next 4 KB page boundary.
    function automatic logic [4:0] calc_beats(input logic [28:0] addr, input logic [15:0] words);
        logic [9:0] room;
        logic [4:0] b;
        room = 10'(AXI_4KB_WORDS) - {1'b0, addr[8:0]};
        b    = 5'(MAX_BURST_BEATS);
        if (words < 16'(MAX_BURST_BEATS)) begin
            b = words[4:0];
        end
        if (room < {5'b0, b}) begin
            b = room[4:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_same_clock_fill.sv
// rtl/fifo_same_clock_fill.sv - single-clock FIFO with fill level, first-word fall-through
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset of pointers/fill
//   sync_rst  synchronous active-high reset of pointers/fill
//   we        push data_in (caller guarantees not full)
//   re        pop head entry (caller guarantees not empty)
//   data_in   write data
//   data_out  head entry, valid while fill != 0
//   fill      number of entries held
module fifo_same_clock_fill #(
    parameter int WIDTH      = 4,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync_rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic [DEPTH_LOG2:0]   fill
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   FILL_ONE = 1;

    logic [WIDTH-1:0]      mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else if (sync_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (we) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (re) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (we && !re) begin
                fill_q <= fill_q + FILL_ONE;
            end else if (re && !we) begin
                fill_q <= fill_q - FILL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign fill     = fill_q;

endmodule

// File: rtl/axi_hp_burst_reader.sv
// rtl/axi_hp_burst_reader.sv - splits one read command into 4 KB-safe INCR bursts and streams the data
//
// Ports:
//   aclk, rst                  clock, synchronous active-high reset
//   start/start_addr/num_words command (word address [31:3], length in 64-bit words)
//   busy/done/error            command status; error is sticky until the next accepted start
//   ar*                        AXI_HP read address channel (64-bit, INCR, constant id/cache/qos)
//   r*                         AXI_HP read data channel
//   dout/dout_valid/dout_ready downstream stream, dout mirrors rdata
module axi_hp_burst_reader
    import axi_hp_burst_reader_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [5:0] ARID_VAL        = 6'h0,
    parameter logic [3:0] ARCACHE_VAL     = 4'h3,
    parameter logic [3:0] ARQOS_VAL       = 4'h0
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        start,
    input  logic [28:0] start_addr,
    input  logic [15:0] num_words,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [5:0]  arid,
    output logic [3:0]  arlen,
    output logic [1:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic [3:0]  arqos,
    input  logic [63:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    input  logic [5:0]  rid,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready
);

    state_e      state_q, state_d;
    logic [28:0] cur_addr_q, cur_addr_d;
    logic [15:0] words_left_q, words_left_d;
    logic [4:0]  beats_q, beats_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        error_q, error_d;
    logic        ar_gap_q, ar_gap_d;

    logic        ar_hs;
    logic        r_hs;
    logic        have_head;
    logic        beat_last;
    logic        fifo_push;
    logic        fifo_pop;
    logic [3:0]  fifo_head;
    logic [LEN_FIFO_DEPTH_LOG2:0] fifo_fill;

    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_FIN);
    assign error      = error_q;

    // One idle cycle after each AR handshake keeps the AR rate at one per two cycles.
    assign arvalid    = (state_q == ST_ISSUE) && !ar_gap_q && (outstanding_q < 4'(MAX_OUTSTANDING));
    assign araddr     = {cur_addr_q, 3'b000};
    assign arlen      = arlen_q;
    assign arid       = ARID_VAL;
    assign arsize     = AXI_SIZE_64;
    assign arburst    = AXI_BURST_INCR;
    assign arlock     = 2'b00;
    assign arcache    = ARCACHE_VAL;
    assign arprot     = 3'b000;
    assign arqos      = ARQOS_VAL;

    assign dout       = rdata;
    assign dout_valid = rvalid && busy;
    assign rready     = dout_ready && busy;

    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;

    // Burst boundaries come from the lengths we requested, not from rlast,
    // so a misbehaving slave cannot desynchronise the accounting.
    assign have_head  = (fifo_fill != '0);
    assign beat_last  = have_head && (beat_cnt_q == fifo_head);
    assign fifo_push  = ar_hs;
    assign fifo_pop   = r_hs && beat_last;

    fifo_same_clock_fill #(
        .WIDTH      (4),
        .DEPTH_LOG2 (LEN_FIFO_DEPTH_LOG2)
    ) u_len_fifo (
        .clk      (aclk),
        .rst      (1'b0),
        .sync_rst (rst),
        .we       (fifo_push),
        .re       (fifo_pop),
        .data_in  (arlen_q),
        .data_out (fifo_head),
        .fill     (fifo_fill)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (fifo_push && !fifo_pop) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (fifo_pop && !fifo_push) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        beats_d      = beats_q;
        arlen_d      = arlen_q;
        beat_cnt_d   = beat_cnt_q;
        error_d      = error_q;
        ar_gap_d     = 1'b0;

        if (r_hs) begin
            if (!have_head || (rlast != beat_last) || (rresp != 2'b00) || (rid != ARID_VAL)) begin
                error_d = 1'b1;
            end
            if (beat_last) begin
                beat_cnt_d = 4'd0;
            end else if (have_head) begin
                beat_cnt_d = beat_cnt_q + 4'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (num_words != 16'd0) begin
                        cur_addr_d   = start_addr;
                        words_left_d = num_words;
                        beats_d      = calc_beats(start_addr, num_words);
                        arlen_d      = 4'(beats_d - 5'd1);
                        state_d      = ST_ISSUE;
                    end else begin
                        state_d      = ST_FIN;
                    end
                end
            end
            ST_ISSUE: begin
                if (ar_hs) begin
                    cur_addr_d   = cur_addr_q + 29'(beats_q);
                    words_left_d = words_left_q - 16'(beats_q);
                    beats_d      = calc_beats(cur_addr_d, words_left_d);
                    arlen_d      = 4'(beats_d - 5'd1);
                    ar_gap_d     = 1'b1;
                    if (words_left_d == 16'd0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Looking at the next-state count lets done follow the final beat by one cycle.
                if (outstanding_d == 4'd0) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            words_left_q  <= '0;
            beats_q       <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            error_q       <= 1'b0;
            ar_gap_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            words_left_q  <= words_left_d;
            beats_q       <= beats_d;
            arlen_q       <= arlen_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            error_q       <= error_d;
            ar_gap_q      <= ar_gap_d;
        end
    end

endmodule

// File: tb/tb_axi_hp_burst_reader.sv
// tb/tb_axi_hp_burst_reader.sv - directed table-driven bench with an AXI_HP read slave model
module tb_axi_hp_burst_reader;

    localparam int MAXO = 2;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [28:0] start_addr;
    logic [15:0] num_words;
    logic        busy, done, error;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [5:0]  arid;
    logic [3:0]  arlen;
    logic [1:0]  arsize, arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [63:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [5:0]  rid;
    logic        rlast;
    logic [1:0]  rresp;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    axi_hp_burst_reader #(
        .MAX_OUTSTANDING (MAXO),
        .ARID_VAL        (6'h0),
        .ARCACHE_VAL     (4'h3),
        .ARQOS_VAL       (4'h0)
    ) dut (
        .aclk       (aclk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .arid       (arid),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arlock     (arlock),
        .arcache    (arcache),
        .arprot     (arprot),
        .arqos      (arqos),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (rid),
        .rlast      (rlast),
        .rresp      (rresp),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave controls, written only by the main sequence.
    bit hold_r      = 1'b0;
    bit early_mode  = 1'b0;
    bit rresp_mode  = 1'b0;
    bit toggle_mode = 1'b0;

    // Slave state and logs, written only by the slave process.
    logic [28:0] bq_addr[$];
    int          bq_len[$];
    int          beat_idx = 0;
    logic [31:0] ar_log_addr[$];
    logic [3:0]  ar_log_len[$];
    logic [63:0] got[$];
    int          done_cnt = 0;
    int          mirror_bad = 0;

    // Slave: handshakes are sampled on the falling edge, state moves after the rising edge.
    initial begin
        bit          rst_s, ar_s, r_s;
        logic [31:0] a_s;
        logic [3:0]  l_s;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; rid = 6'h0;
        arready = 1'b1; dout_ready = 1'b1;
        forever begin
            @(negedge aclk);
            rst_s = rst;
            ar_s  = arvalid && arready;
            r_s   = rvalid && rready;
            a_s   = araddr;
            l_s   = arlen;
            if (ar_s) begin
                ar_log_addr.push_back(araddr);
                ar_log_len.push_back(arlen);
            end
            if (dout_valid && dout_ready) got.push_back(dout);
            if (done) done_cnt++;
            if (busy && (rready !== dout_ready)) mirror_bad++;
            @(posedge aclk);
            #2;
            if (rst_s) begin
                bq_addr.delete();
                bq_len.delete();
                beat_idx = 0;
            end else begin
                if (r_s && bq_len.size() > 0) begin
                    beat_idx++;
                    if (beat_idx > bq_len[0]) begin
                        void'(bq_addr.pop_front());
                        void'(bq_len.pop_front());
                        beat_idx = 0;
                    end
                end
                if (ar_s) begin
                    bq_addr.push_back(a_s[31:3]);
                    bq_len.push_back(int'(l_s));
                end
            end
            dout_ready = toggle_mode ? !dout_ready : 1'b1;
            if (!hold_r && bq_len.size() > 0) begin
                rvalid = 1'b1;
                rdata  = 64'(bq_addr[0] + 29'(beat_idx));
                rlast  = (beat_idx == bq_len[0]) ||
                         (early_mode && bq_len[0] == 15 && beat_idx == 2);
                rresp  = rresp_mode ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
    end

    typedef struct {
        logic [31:0] byte_addr;
        logic [15:0] nwords;
        int          n_ar;
        logic [31:0] ar_addr [4];
        logic [3:0]  ar_len  [4];
        bit          early;
        bit          rresp_err;
        bit          toggle;
        bit          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic start_cmd(input logic [31:0] byte_addr, input logic [15:0] n);
        @(posedge aclk); #1;
        start      = 1'b1;
        start_addr = byte_addr[31:3];
        num_words  = n;
        @(posedge aclk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge aclk);
            if (done) break;
        end
        chk($sformatf("%s_done_seen", tag), 64'(k < 3000), 64'd1);
    endtask

    task automatic check_cmd(input vec_t v, input string tag, input int b_ar, input int b_got,
                             input int b_done, input int b_mir);
        int bad;
        chk($sformatf("%s_n_ar", tag), 64'(ar_log_addr.size() - b_ar), 64'(v.n_ar));
        for (int i = 0; i < v.n_ar; i++) begin
            if (b_ar + i < ar_log_addr.size()) begin
                chk($sformatf("%s_araddr%0d", tag, i), 64'(ar_log_addr[b_ar + i]), 64'(v.ar_addr[i]));
                chk($sformatf("%s_arlen%0d", tag, i), 64'(ar_log_len[b_ar + i]), 64'(v.ar_len[i]));
            end
        end
        chk($sformatf("%s_beats", tag), 64'(got.size() - b_got), 64'(v.nwords));
        bad = 0;
        for (int i = b_got; i < got.size(); i++) begin
            if (got[i] !== 64'(v.byte_addr[31:3] + 29'(i - b_got))) bad++;
        end
        chk($sformatf("%s_data_order", tag), 64'(bad), 64'd0);
        chk($sformatf("%s_done_pulses", tag), 64'(done_cnt - b_done), 64'd1);
        chk($sformatf("%s_error", tag), 64'(error), 64'(v.exp_err));
        chk($sformatf("%s_rready_mirror", tag), 64'(mirror_bad - b_mir), 64'd0);
        chk($sformatf("%s_idle", tag), 64'(busy), 64'd0);
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int b_ar, b_got, b_done, b_mir;
        b_ar = ar_log_addr.size(); b_got = got.size(); b_done = done_cnt; b_mir = mirror_bad;
        start_cmd(v.byte_addr, v.nwords);
        chk($sformatf("%s_ar_latency", tag), 64'(arvalid), 64'd1);
        wait_done(tag);
        repeat (2) @(posedge aclk);
        #1;
        check_cmd(v, tag, b_ar, b_got, b_done, b_mir);
    endtask

    initial begin
        int b_ar, b_done;
        start = 1'b0; start_addr = '0; num_words = '0;

        vecs[0] = '{32'h1000, 16'd40, 3, '{32'h1000, 32'h1080, 32'h1100, 32'h0}, '{4'd15, 4'd15, 4'd7, 4'd0}, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h1FE8, 16'd10, 2, '{32'h1FE8, 32'h2000, 32'h0, 32'h0}, '{4'd2, 4'd6, 4'd0, 4'd0}, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h0F80, 16'd20, 2, '{32'h0F80, 32'h1000, 32'h0, 32'h0}, '{4'd15, 4'd3, 4'd0, 4'd0}, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h1FF8, 16'd3, 2, '{32'h1FF8, 32'h2000, 32'h0, 32'h0}, '{4'd0, 4'd1, 4'd0, 4'd0}, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000, 16'd16, 1, '{32'h0000, 32'h0, 32'h0, 32'h0}, '{4'd15, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0008, 16'd1, 1, '{32'h0008, 32'h0, 32'h0, 32'h0}, '{4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0040, 16'd4, 1, '{32'h0040, 32'h0, 32'h0, 32'h0}, '{4'd3, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h2000, 16'd16, 1, '{32'h2000, 32'h0, 32'h0, 32'h0}, '{4'd15, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h1000, 16'd40, 3, '{32'h1000, 32'h1080, 32'h1100, 32'h0}, '{4'd15, 4'd15, 4'd7, 4'd0}, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("const_ar_fields", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
            {6'h0, 2'h3, 2'b01, 2'b00, 4'h3, 3'b000, 4'h0});
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            early_mode  = vecs[i].early;
            rresp_mode  = vecs[i].rresp_err;
            toggle_mode = vecs[i].toggle;
            run_cmd(vecs[i], $sformatf("v%0d", i));
            early_mode  = 1'b0;
            rresp_mode  = 1'b0;
            toggle_mode = 1'b0;
        end

        // Zero-length command: done the cycle after start, no address phase.
        b_ar = ar_log_addr.size(); b_done = done_cnt;
        start_cmd(32'h0080, 16'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_arvalid", 64'(arvalid), 64'd0);
        @(posedge aclk); #1;
        chk("zero_done_once", 64'(done), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
        chk("zero_no_ar", 64'(ar_log_addr.size() - b_ar), 64'd0);
        chk("zero_done_pulses", 64'(done_cnt - b_done), 64'd1);

        // Outstanding cap: data withheld, only MAXO bursts may be issued.
        begin
            int c_ar, c_got, c_done, c_mir;
            c_ar = ar_log_addr.size(); c_got = got.size(); c_done = done_cnt; c_mir = mirror_bad;
            hold_r = 1'b1;
            start_cmd(vecs[0].byte_addr, vecs[0].nwords);
            repeat (20) @(posedge aclk);
            #1;
            chk("cap_ar_count", 64'(ar_log_addr.size() - c_ar), 64'(MAXO));
            chk("cap_arvalid_low", 64'(arvalid), 64'd0);
            chk("cap_busy", 64'(busy), 64'd1);
            hold_r = 1'b0;
            wait_done("cap");
            repeat (2) @(posedge aclk);
            #1;
            check_cmd(vecs[0], "cap", c_ar, c_got, c_done, c_mir);
        end

        // Reset in the middle of a multi-burst read, then a clean command.
        start_cmd(vecs[0].byte_addr, vecs[0].nwords);
        repeat (6) @(posedge aclk);
        #1;
        chk("mid_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge aclk); #1;
        chk("mid_rst_outputs", {busy, done, error, arvalid, rready, dout_valid},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("mid_rst_araddr", 64'(araddr), 64'd0);
        chk("mid_rst_arlen", 64'(arlen), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge aclk);
        run_cmd(vecs[1], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
